spi_reg_bank: RTL
=================

// Module: spi_reg_bank
// PURPOSE
//   Parametrised SPI (mode 0, MSB first) register bank. Successor to the fixed 5-register write-only peripheral.
//   Adds three things: a single clock domain (SPI pins oversampled on clk), parametrised register count and
//   widths, and read-back on CIPO. Frame errors are flagged and counted.
//   Sits between the chip pins and the PWM/output-enable logic, which consume reg_q.
// PARAMETERS
//   NUM_REGS    5  number of DATA_W registers; valid addresses 0..NUM_REGS-1
//   ADDR_W      7  address field width
//   DATA_W      8  data field width; FRAME_W = 1+ADDR_W+DATA_W (16 at defaults)
//   SYNC_STAGES 2  synchroniser depth on sclk/ncs/copi (>=2)
// PORTS
//   clk       in   1                  system clock
//   rst_n     in   1                  asynchronous active-low reset
//   sclk      in   1                  SPI clock pin (async)
//   ncs       in   1                  SPI chip select, active low (async)
//   copi      in   1                  SPI data in (async)
//   cipo      out  1                  SPI data out, read data MSB first
//   cipo_oe   out  1                  CIPO pad output enable
//   reg_q     out  NUM_REGS*DATA_W    register contents; reg i at [i*DATA_W +: DATA_W]
//   wr_pulse  out  1                  one-clk pulse when a register is written
//   wr_addr   out  ADDR_W             address of last write; valid while wr_pulse=1
//   frame_err out  1                  one-clk pulse on a bad frame
//   err_cnt   out  8                  count of bad frames, saturates at 255
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in IDLE. The ncs synchroniser resets to 1 and sclk to 0,
//   so reset release never produces a false edge.
// - Reset mid-frame discards the frame with no write and no error.
// - Pin sync: SYNC_STAGES flops per pin, plus one extra flop on sclk and ncs for edge detection.
//   sclk high and low times must each be >= SYNC_STAGES+2 clk periods.
// - Frame format: bit0 = R/W (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits; all MSB first.
//   copi is sampled on synced sclk rising edges.
// - FSM states: IDLE, CMD, DATA, OVR.
//   - IDLE -> CMD on synced ncs falling edge; clear bit counter and shift register.
//   - CMD: shift in 1+ADDR_W bits. At the first sclk falling edge after they are in, go to DATA.
//     If the command is a read with a valid address, load tx_shift with that register, else with 0.
//   - DATA: shift copi in on sclk rises. Shift tx_shift left on sclk falls, filling with 0.
//     After DATA_W rises, go to OVR.
//   - OVR: any further sclk rise sets the over-length flag; counter holds.
//   - Any state -> IDLE on synced ncs rising edge.
// - Commit happens in the clk cycle after the synced ncs rise. A frame is good only if exactly FRAME_W bits
//   were received.
//   - Good write to a valid address: reg_q[addr] <= data; wr_pulse=1; wr_addr=addr.
//   - Good read: no register change, no pulse.
//   - Otherwise frame_err=1 and err_cnt increments (holds at 255). Otherwise covers: too short, too long,
//     or a write to addr >= NUM_REGS.
//   - ncs rise with zero bits received: silently ignored, no error.
// - Latency: pin ncs rise -> reg_q updated = SYNC_STAGES+2 clk.
// - cipo = tx_shift[DATA_W-1] while in DATA for a read, else 0.
//   cipo_oe = 1 only in DATA for a read while synced ncs is low.
// - Read of an invalid address returns all zeros, and the frame still counts as good.
// - Write and read share one frame only in the sense of R/W. A frame is never both.
// - If reset was released while ncs is low, the FSM stays in IDLE until the next ncs fall.
//   Bits seen in that state are ignored.
// TESTING
//   Write 0x80F0 (addr0, data F0) -> reg0=F0, wr_pulse 1 clk, wr_addr=0, others unchanged.
//   Write 0x84A5 to addr4 (defaults) -> reg4=A5. Then read frame 0x0400 -> CIPO shifts 1010_0101, cipo_oe high in data phase only.
//   Write to addr 5 (NUM_REGS=5) -> no reg change, frame_err pulse, err_cnt=1.
//   15-bit frame, then a 17-bit frame -> no writes, err_cnt=2. Then ncs toggled with 0 sclk -> err_cnt stays 2.
//   rst_n low after 10 bits of a write -> all outputs 0. Next full write 0x81FF -> reg1=FF.
//   Force err_cnt to 255 via 256 bad frames -> stays 255. Rerun at NUM_REGS=8, DATA_W=16 -> addr7 write/read 0xBEEF.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank, MSB first.
// Pins oversampled on clk; read-back on cipo.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err,
  output logic [7:0]                 err_cnt
);

  localparam int CMD_W   = 1 + ADDR_W;
  localparam int FRAME_W = CMD_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    OVR
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  logic [SYNC_STAGES:0]   warm;
  logic                   armed;

  logic sclk_s;
  logic ncs_s;
  logic copi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ncs_rise;
  logic ncs_fall;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  rx;
  logic [DATA_W-1:0]   tx;
  logic                ovr;
  logic                rd_mode;
  logic                cmt;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_hit;
  logic [DATA_W-1:0] rd_word;
  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              f_hit;
  logic              f_good;

  // pin synchronisers; ncs idles high so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '1;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  // arm only after a real ncs-high seen past the sync chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (warm[SYNC_STAGES] && ncs_s && ncs_d)
        armed <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = armed & ~ncs_s & ncs_d;

  assign cmd_rw   = rx[ADDR_W];
  assign cmd_addr = rx[ADDR_W-1:0];
  assign f_rw     = rx[FRAME_W-1];
  assign f_addr   = rx[DATA_W +: ADDR_W];
  assign f_data   = rx[DATA_W-1:0];
  assign f_good   = (cnt == CNT_W'(FRAME_W)) && !ovr;

  // register lookup for read command and commit address
  always_comb begin
    cmd_hit = 1'b0;
    rd_word = '0;
    f_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) begin
        cmd_hit = 1'b1;
        rd_word = regs[i];
      end
      if (f_addr == ADDR_W'(i))
        f_hit = 1'b1;
    end
  end

  // frame FSM: shift in, shift out, flag over-length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rx      <= '0;
      tx      <= '0;
      ovr     <= 1'b0;
      rd_mode <= 1'b0;
      cmt     <= 1'b0;
    end else begin
      cmt <= 1'b0;
      if (ncs_rise && state != IDLE) begin
        state   <= IDLE;
        cmt     <= 1'b1;
        rd_mode <= 1'b0;
        tx      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ncs_fall) begin
              state <= CMD;
              cnt   <= '0;
              rx    <= '0;
              tx    <= '0;
              ovr   <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise && cnt < CNT_W'(CMD_W)) begin
              rx  <= {rx[FRAME_W-2:0], copi_s};
              cnt <= cnt + 1'b1;
            end else if (sclk_fall && cnt == CNT_W'(CMD_W)) begin
              state   <= DATA;
              rd_mode <= ~cmd_rw;
              tx      <= (!cmd_rw && cmd_hit) ? rd_word : '0;
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx  <= {rx[FRAME_W-2:0], copi_s};
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(FRAME_W - 1)) begin
                state   <= OVR;
                rd_mode <= 1'b0;
              end
            end else if (sclk_fall) begin
              tx <= {tx[DATA_W-2:0], 1'b0};
            end
          end
          OVR: begin
            if (sclk_rise)
              ovr <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // commit the finished frame one clk after ncs rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (cmt && cnt != '0) begin
        if (f_good && f_rw && f_hit) begin
          wr_pulse <= 1'b1;
          wr_addr  <= f_addr;
          for (int i = 0; i < NUM_REGS; i++)
            if (f_addr == ADDR_W'(i))
              regs[i] <= f_data;
        end else if (!(f_good && !f_rw)) begin
          frame_err <= 1'b1;
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  assign cipo    = rd_mode & tx[DATA_W-1];
  assign cipo_oe = rd_mode & ~ncs_s;

endmodule
